regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the tinyCPU datapath, sitting between decode (read addresses) and writeback (write port). It generalises the original 32x32 file with configurable width, depth and read-port count, a sequenced post-reset initialisation with a `ready` flag, write-to-read bypass, a freeze input for the board's debug switch, and an independent debug read port for the display path. Optional sign-magnitude storage is kept behind a parameter.

## Interface
- `XLEN`, 32: data width in bits.
- `NREG`, 32: number of registers; power of two, at least 4. `AW = log2(NREG)` is derived.
- `NRD`, 2: number of architectural read ports, from 1 to 4.
- `INIT_MODE`, 1: post-reset contents. 0 means all zero; 1 means register i = i, zero-extended to `XLEN`.
- `SIGNMAG`, 0: when 1, a negative write value (MSB=1) is stored as `{1'b1, (~wr_data[XLEN-2:0]) + 1}`, truncated to `XLEN-1` bits. When 0, the value is stored unchanged.

- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `freeze`, in, 1: when 1, architectural writes are blocked (debug mode, driven from `sw_i[1]`).
- `wr_en`, in, 1: write request.
- `wr_addr`, in, `AW`: write address.
- `wr_data`, in, `XLEN`: write data.
- `rd_addr`, in, `NRD*AW`: read addresses; port p occupies `[p*AW +: AW]`.
- `rd_data`, out, `NRD*XLEN`: registered read data; port p occupies `[p*XLEN +: XLEN]`.
- `dbg_addr`, in, `AW`: debug read address.
- `dbg_data`, out, `XLEN`: registered debug read data.
- `ready`, out, 1: high once initialisation is complete.
- `wr_drop`, out, 1: one-cycle pulse when a `wr_en` request was discarded.

## Operation
- **FSM states:** `INIT` and `RUN`.
  - `reset`=1 at an edge forces `INIT`, sets the init counter `icnt` to 0, and clears `ready`, all `rd_data`, `dbg_data` and `wr_drop` to 0.
- **`INIT` state:**
  - Each cycle writes `reg[icnt]` with the init value: 0 if `INIT_MODE`=0, otherwise `icnt` (with reg 0 always 0). `icnt` then increments.
  - When `icnt == NREG-1` is written, the FSM moves to `RUN` and `ready` goes to 1 at that same edge.
  - No other transition exists out of `INIT`.
- **`RUN` state:** no exit except `reset`.
- **Write acceptance:** a write is accepted only when all of the following hold: state is `RUN`, `wr_en`=1, `freeze`=0 and `wr_addr` != 0.
  - An accepted write stores the value after the optional `SIGNMAG` conversion.
- **Write drops:**
  - `wr_drop` is 1 for the cycle after an edge where `wr_en`=1 and (`freeze`=1 or state is `INIT`).
  - A write to address 0 is silently ignored and does not assert `wr_drop`.
- **Reads:** at every edge in `RUN`, each port p registers `reg[rd_addr_p]`. Two overrides apply:
  - If `rd_addr_p`=0, the port registers 0.
  - If a write is accepted at the same edge with `wr_addr == rd_addr_p`, the port registers the stored (converted) write value. This is the bypass.
- **Debug port:** `dbg_data` follows the same rules as the read ports, including bypass. It ignores `freeze`, so the display stays live while writes are frozen.
- **Reads during `INIT`:** all `rd_data` and `dbg_data` register 0.
- **Port independence:** all read ports and the debug port are independent; identical addresses on several ports return identical data.
- **Width rules:** the `SIGNMAG` negation is modulo `2^(XLEN-1)`.
  - The most-negative input (`1` followed by all zeros) stores as `1` followed by all zeros.

## Timing
- **Read latency:** 1 cycle. Addresses presented before edge k appear on `rd_data` after edge k.
- **Write visibility:** an accepted write at edge k is visible at that same edge through bypass. It is visible through the array to reads sampled at edge k+1 onward.
- **Init duration:** deasserting `reset` before edge 0 gives `NREG` init edges (0 .. `NREG-1`).
  - `ready`=1 after edge `NREG-1`.
  - The first accepted write can occur at edge `NREG`.
- **Reset mid-`INIT`:** `icnt` restarts at 0 and the full `NREG`-cycle sequence repeats. Partially initialised contents are overwritten.
- **Reset mid-`RUN`:** the contents are reinitialised over `NREG` cycles. Writes presented during that time are dropped and `wr_drop` pulses.
- **Simultaneous `reset` and `wr_en`:** `reset` wins; no write occurs and `wr_drop`=0.
- **`freeze` changes:** `freeze` takes effect at the edge where it is sampled; there is no pipeline delay.

## Test plan
- **Init sequence** (`INIT_MODE`=1, `NREG`=32): pulse `reset` for 1 cycle.
  - `ready`=0 for 32 edges, then 1.
  - Reads of addresses 0, 5 and 31 return 0, 5 and 31.
  - A `wr_en` issued during `INIT` gives `wr_drop`=1 and leaves the contents unchanged.
- **Bypass:** in `RUN`, write `wr_addr`=7 with `wr_data`=`0x1234` while port0 and port1 both read 7 at the same edge.
  - Both ports show `0x1234` on the next cycle.
  - Reading 7 again the following cycle returns `0x1234`.
- **x0 hardwired:** write `0xFFFF_FFFF` to address 0.
  - Port0 reading 0 returns 0 on both the same-edge read and later reads.
  - `wr_drop` stays 0.
- **Freeze:** with `freeze`=1, write `0xAA` to address 3.
  - `wr_drop` pulses for 1 cycle.
  - Address 3 still reads 3.
  - `dbg_addr`=3 gives `dbg_data`=3.
  - Drop `freeze` and repeat the write; address 3 then reads `0xAA`.
- **Sign-magnitude** (`SIGNMAG`=1): write `0xFFFF_FFFB` (-5).
  - The register reads `0x8000_0005`.
  - Writing `0x8000_0000` reads back `0x8000_0000`.
- **Reset mid-`RUN`:** after writing `0x55` to address 9, assert `reset` together with a `wr_en` to address 9.
  - No write occurs.
  - `ready` drops.
  - After 32 cycles, address 9 reads 9.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with sequenced init, write bypass, freeze and debug read port
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int INIT_MODE = 1,
  parameter int SIGNMAG = 0,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                ready,
  output logic                wr_drop
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [XLEN-2:0] LSB1 = {{(XLEN-2){1'b0}}, 1'b1};
  state_t             state_q;
  logic [AW-1:0]      icnt_q;
  logic [XLEN-1:0]    mem_q [NREG];
  logic [NRD*XLEN-1:0] rd_q, rd_d;
  logic [XLEN-1:0]    dbg_q, dbg_d, wr_val;
  logic               ready_q, drop_q, wr_acc;
  always_comb begin
    wr_val = (SIGNMAG != 0 && wr_data[XLEN-1]) ? {1'b1, ~wr_data[XLEN-2:0] + LSB1} : wr_data;
    wr_acc = state_q == RUN && wr_en && !freeze && wr_addr != '0;
    dbg_d  = dbg_addr == '0 ? '0 : (wr_acc && wr_addr == dbg_addr) ? wr_val : mem_q[dbg_addr];
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_d[p*XLEN +: XLEN] = a == '0 ? '0 : (wr_acc && wr_addr == a) ? wr_val : mem_q[a];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      icnt_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
      rd_q    <= '0;
      dbg_q   <= '0;
    end else begin
      drop_q <= wr_en && (freeze || state_q == INIT);
      if (state_q == INIT) begin
        mem_q[icnt_q] <= INIT_MODE != 0 ? XLEN'(icnt_q) : '0;
        icnt_q <= icnt_q + AW'(1);
        rd_q   <= '0;
        dbg_q  <= '0;
        if (icnt_q == AW'(NREG-1)) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end else begin
        if (wr_acc) mem_q[wr_addr] <= wr_val;
        rd_q  <= rd_d;
        dbg_q <= dbg_d;
      end
    end
  end
  assign rd_data  = rd_q;
  assign dbg_data = dbg_q;
  assign ready    = ready_q;
  assign wr_drop  = drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving a plain and a sign-magnitude register file in lockstep
module tb_regfile_mp;
  logic        clk = 1'b0, reset = 1'b1, freeze = 1'b0, wr_en = 1'b0;
  logic [4:0]  wr_addr = '0, dbg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [1:0][63:0] rd_data;
  logic [1:0][31:0] dbg_data;
  logic [1:0]  ready, wr_drop;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  regfile_mp #(.SIGNMAG(0)) u0 (.clk(clk), .reset(reset), .freeze(freeze), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data[0]),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data[0]), .ready(ready[0]), .wr_drop(wr_drop[0]));
  regfile_mp #(.SIGNMAG(1)) u1 (.clk(clk), .reset(reset), .freeze(freeze), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data[1]),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data[1]), .ready(ready[1]), .wr_drop(wr_drop[1]));
  typedef struct packed {
    logic [1:0] rdy, drp;
    logic [1:0][63:0] rd;
    logic [1:0][31:0] dbg;
  } exp_t;
  exp_t q[$];
  logic [31:0] m [2][32];
  logic in_init = 1'b1;
  int icnt = 0;
  // Sign-magnitude store value: sign bit kept, magnitude is 2^31 minus the low 31 bits, mod 2^31
  function automatic logic [31:0] conv(input int sm, input logic [31:0] d);
    logic [31:0] mag;
    if (sm == 0 || !d[31]) return d;
    mag = (32'h8000_0000 - {1'b0, d[30:0]}) & 32'h7FFF_FFFF;
    return 32'h8000_0000 | mag;
  endfunction
  function automatic logic [31:0] look(input int k, input int a, input logic acc, input int wa, input logic [31:0] v);
    if (a == 0) return 32'h0;
    if (acc && wa == a) return v;
    return m[k][a];
  endfunction
  task automatic step(input logic r, input logic we, input int wa, input logic [31:0] wd,
                      input int a0, input int a1, input int da, input logic fz);
    exp_t e;
    logic acc;
    e = '0;
    reset = r; wr_en = we; wr_addr = 5'(wa); wr_data = wd; freeze = fz;
    rd_addr = {5'(a1), 5'(a0)}; dbg_addr = 5'(da);
    if (r) begin
      in_init = 1'b1;
      icnt = 0;
    end else if (in_init) begin
      e.drp = {we, we};
      for (int k = 0; k < 2; k++) m[k][icnt] = 32'(icnt);
      if (icnt == 31) begin
        e.rdy = 2'b11;
        in_init = 1'b0;
      end
      icnt++;
    end else begin
      acc = we && !fz && wa != 0;
      e.drp = {we && fz, we && fz};
      e.rdy = 2'b11;
      for (int k = 0; k < 2; k++) begin
        e.rd[k] = {look(k, a1, acc, wa, conv(k, wd)), look(k, a0, acc, wa, conv(k, wd))};
        e.dbg[k] = look(k, da, acc, wa, conv(k, wd));
        if (acc) m[k][wa] = conv(k, wd);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int a0, input int a1, input int da);
    step(1'b0, 1'b0, 0, 32'h0, a0, a1, da, 1'b0);
  endtask
  task automatic wr(input int wa, input logic [31:0] wd, input int a0, input int a1, input logic fz);
    step(1'b0, 1'b1, wa, wd, a0, a1, wa, fz);
  endtask
  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, 64'(ready[k]), 64'(e.rdy[k]));
        chk("wr_drop", k, 64'(wr_drop[k]), 64'(e.drp[k]));
        chk("rd_data", k, rd_data[k], e.rd[k]);
        chk("dbg_data", k, 64'(dbg_data[k]), 64'(e.dbg[k]));
      end
    end
  end
  initial begin
    int wa;
    logic we, fz;
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 4, 32'h77, 0, 0, 0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, i == 10, 4, 32'hDEAD, i, 31 - i, i, 1'b0);
    rd(0, 5, 31);
    rd(4, 31, 5);
    wr(7, 32'h1234, 7, 7, 1'b0);
    rd(7, 7, 7);
    wr(0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    rd(0, 0, 0);
    wr(3, 32'hAA, 3, 3, 1'b1);
    rd(3, 3, 3);
    wr(3, 32'hAA, 3, 0, 1'b0);
    rd(3, 3, 3);
    wr(10, 32'hFFFF_FFFB, 10, 10, 1'b0);
    rd(10, 10, 10);
    wr(11, 32'h8000_0000, 11, 11, 1'b0);
    rd(11, 11, 11);
    wr(9, 32'h55, 9, 9, 1'b0);
    rd(9, 9, 9);
    step(1'b1, 1'b1, 9, 32'h77, 9, 9, 9, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, i % 7 == 3, 9, 32'h99, 9, i, 9, 1'b0);
    rd(9, 9, 9);
    step(1'b0, 1'b0, 0, 0, 9, 9, 9, 1'b1);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 0, 1, 2, 3, 1'b0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      we = $urandom_range(0, 2) != 0;
      fz = $urandom_range(0, 3) == 0;
      wa = we ? $urandom_range(1, 31) : $urandom_range(0, 31);
      step($urandom_range(0, 199) == 0, we, wa, $urandom, $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), fz);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
